// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the 1D CNN datapath.
// Holds the frame accumulator state encoding and parameter checks.
package cnn1d_pkg;

    typedef enum logic {ACCUMULATE, OUTPUT} acc_state_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/frame_accumulator_sat_trunc.sv
// sat_trunc: combinational signed saturating narrower.
// Clamps a signed IN_WIDTH value into the signed OUT_WIDTH range.
module sat_trunc #(
    parameter int IN_WIDTH  = 36,
    parameter int OUT_WIDTH = 32
) (
    input  logic signed [IN_WIDTH-1:0]  in_i,
    output logic signed [OUT_WIDTH-1:0] out_o
);

    localparam int HW = IN_WIDTH - OUT_WIDTH + 1;

    logic [HW-1:0] head;

    // In range exactly when every bit above the output MSB copies the sign.
    assign head = in_i[IN_WIDTH-1:OUT_WIDTH-1];

    always_comb begin
        if (head == '0 || head == '1) begin
            out_o = in_i[OUT_WIDTH-1:0];
        end else if (in_i[IN_WIDTH-1]) begin
            out_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            out_o = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/frame_accumulator.sv
// Sums FRAME_LEN signed samples and emits one saturated result per frame.
// Define ACC_MEAN_EN to output the frame mean (power-of-two FRAME_LEN).
module frame_accumulator
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRACTION   = 24,
    parameter int FRAME_LEN  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          acc_ready_in,
    input  logic                          acc_valid_in,
    input  logic [DATA_WIDTH-1:0]         acc_data_in,
    input  logic                          acc_ready_out,
    output logic                          acc_valid_out,
    output logic [DATA_WIDTH-1:0]         acc_data_out,
    output logic [$clog2(FRAME_LEN+1)-1:0] acc_count
);

    localparam int SHIFT     = $clog2(FRAME_LEN);
    localparam int ACC_WIDTH = DATA_WIDTH + SHIFT + 1;
    localparam int CW        = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    if (FRAME_LEN < 1) begin : g_len_chk
        $error("frame_accumulator: FRAME_LEN must be >= 1");
    end
    if (FRACTION < 0 || FRACTION >= DATA_WIDTH) begin : g_frac_chk
        $error("frame_accumulator: FRACTION out of range");
    end
`ifdef ACC_MEAN_EN
    if (!is_pow2(FRAME_LEN)) begin : g_pow2_chk
        $error("frame_accumulator: FRAME_LEN must be a power of two");
    end
`endif

    acc_state_t                   state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]        data_q, data_d;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  res;
    logic signed [DATA_WIDTH-1:0] sat_out;
    logic                         in_xfer;
    logic                         out_xfer;

    assign sum = acc_q + {{(ACC_WIDTH-DATA_WIDTH){acc_data_in[DATA_WIDTH-1]}},
                          acc_data_in};

`ifdef ACC_MEAN_EN
    assign res = sum >>> SHIFT;
`else
    assign res = sum;
`endif

    sat_trunc #(
        .IN_WIDTH (ACC_WIDTH),
        .OUT_WIDTH(DATA_WIDTH)
    ) u_sat (
        .in_i (res),
        .out_o(sat_out)
    );

    assign in_xfer  = acc_valid_in && acc_ready_in;
    assign out_xfer = acc_valid_out && acc_ready_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUMULATE;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            ACCUMULATE: begin
                if (in_xfer) begin
                    acc_d = sum;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = OUTPUT;
                        data_d  = sat_out;
                    end
                end
            end
            OUTPUT: begin
                if (out_xfer) begin
                    state_d = ACCUMULATE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ACCUMULATE;
        endcase
    end

    always_comb begin
        acc_ready_in  = (state_q == ACCUMULATE) && !rst;
        acc_valid_out = (state_q == OUTPUT);
        acc_data_out  = data_q;
        acc_count     = cnt_q;
    end

endmodule

// File: tb/tb_frame_accumulator.sv
// Self-checking bench for frame_accumulator (FRAME_LEN = 8).
// Honours ACC_MEAN_EN when defined for the whole build.
module tb_frame_accumulator;

    localparam int DW = 32;
    localparam int FL = 8;
    localparam int CW = $clog2(FL + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          acc_ready_in;
    logic          acc_valid_in = 1'b0;
    logic [DW-1:0] acc_data_in = '0;
    logic          acc_ready_out = 1'b0;
    logic          acc_valid_out;
    logic [DW-1:0] acc_data_out;
    logic [CW-1:0] acc_count;

    frame_accumulator #(
        .DATA_WIDTH(DW),
        .FRACTION  (24),
        .FRAME_LEN (FL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .acc_ready_in (acc_ready_in),
        .acc_valid_in (acc_valid_in),
        .acc_data_in  (acc_data_in),
        .acc_ready_out(acc_ready_out),
        .acc_valid_out(acc_valid_out),
        .acc_data_out (acc_data_out),
        .acc_count    (acc_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    // Reference: running frame sum plus a queue of pending results.
    longint        m_sum = 0;
    int            m_cnt = 0;
    logic [DW-1:0] exp_q[$];

    logic          s_rdy, s_vo;
    logic [DW-1:0] s_dout;
    logic [CW-1:0] s_cnt;

    function automatic logic [DW-1:0] ref_result(input longint s);
        longint v;
        logic [63:0] w;
`ifdef ACC_MEAN_EN
        v = s >>> $clog2(FL);
`else
        v = s;
`endif
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        w = v;
        return w[31:0];
    endfunction

    task automatic chk(input string n, input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
        end
    endtask

    // One cycle: drive at negedge, sample, check, advance to next negedge.
    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic ro, input logic r);
        bit pend;
        acc_valid_in  = v;
        acc_data_in   = d;
        acc_ready_out = ro;
        rst           = r;
        #1;
        s_rdy  = acc_ready_in;
        s_vo   = acc_valid_out;
        s_dout = acc_data_out;
        s_cnt  = acc_count;
        pend   = (exp_q.size() != 0);
        chk("valid_out", {31'b0, s_vo}, {31'b0, pend});
        chk("ready_in", {31'b0, s_rdy}, {31'b0, !pend && !r});
        chk("count", {{(DW-CW){1'b0}}, s_cnt},
            pend ? DW'(FL) : DW'(m_cnt));
        if (s_cnt > CW'(FL)) chk("count_max", {{(DW-CW){1'b0}}, s_cnt}, DW'(FL));
        if (r) begin
            m_sum = 0;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (s_vo && ro && pend) begin
                chk("data_out", s_dout, exp_q.pop_front());
                n_out++;
            end
            if (v && s_rdy) begin
                m_sum += longint'($signed(d));
                m_cnt++;
                if (m_cnt == FL) begin
                    exp_q.push_back(ref_result(m_sum));
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        string         name;
        logic [DW-1:0] sample;
        logic [DW-1:0] exp_v;
    } vec_t;

    vec_t tbl[5];

    initial begin
`ifdef ACC_MEAN_EN
        tbl[0] = '{"one",  32'h0100_0000, 32'h0100_0000};
        tbl[1] = '{"mone", 32'hFF00_0000, 32'hFF00_0000};
        tbl[2] = '{"max",  32'h7FFF_FFFF, 32'h7FFF_FFFF};
        tbl[3] = '{"min",  32'h8000_0000, 32'h8000_0000};
        tbl[4] = '{"half", 32'h0080_0000, 32'h0080_0000};
`else
        tbl[0] = '{"one",  32'h0100_0000, 32'h0800_0000};
        tbl[1] = '{"mone", 32'hFF00_0000, 32'hF800_0000};
        tbl[2] = '{"max",  32'h7FFF_FFFF, 32'h7FFF_FFFF};
        tbl[3] = '{"min",  32'h8000_0000, 32'h8000_0000};
        tbl[4] = '{"half", 32'h0080_0000, 32'h0400_0000};
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        step(1'b0, '0, 1'b1, 1'b1);
        chk("reset_valid", {31'b0, s_vo}, 32'd0);
        chk("reset_data", s_dout, 32'd0);
        chk("reset_ready", {31'b0, s_rdy}, 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("post_reset_ready", {31'b0, s_rdy}, 32'd1);

        // Table: full frames of a constant sample, result the cycle after
        foreach (tbl[i]) begin
            for (int k = 0; k < FL; k++) step(1'b1, tbl[i].sample, 1'b1, 1'b0);
            step(1'b1, tbl[i].sample, 1'b1, 1'b0);
            chk({"lat_vo_", tbl[i].name}, {31'b0, s_vo}, 32'd1);
            chk({"lat_rdy_", tbl[i].name}, {31'b0, s_rdy}, 32'd0);
            chk({"tbl_", tbl[i].name}, s_dout, tbl[i].exp_v);
        end

        // -1 LSB then zeros: both sum and floor mean give all ones
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        for (int k = 1; k < FL; k++) step(1'b1, 32'h0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("neg_lsb", s_dout, 32'hFFFF_FFFF);

        // Backpressure
        for (int k = 0; k < FL; k++) step(1'b1, 32'h0100_0000, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 32'h0100_0000, 1'b0, 1'b0);
            chk("bp_vo", {31'b0, s_vo}, 32'd1);
            chk("bp_rdy", {31'b0, s_rdy}, 32'd0);
            chk("bp_data", s_dout, tbl[0].exp_v);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < FL; k++) step(1'b1, 32'h0080_0000, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("bp_next", s_dout, tbl[4].exp_v);

        // Reset mid-frame
        for (int k = 0; k < 3; k++) step(1'b1, 32'h0100_0000, 1'b1, 1'b0);
        step(1'b1, 32'h0100_0000, 1'b1, 1'b1);
        chk("rst_mid_rdy", {31'b0, s_rdy}, 32'd0);
        step(1'b1, 32'h0080_0000, 1'b1, 1'b0);
        chk("rst_mid_cnt", {{(DW-CW){1'b0}}, s_cnt}, 32'd0);
        for (int k = 1; k < FL; k++) step(1'b1, 32'h0080_0000, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("rst_mid_res", s_dout, tbl[4].exp_v);

        // Reset while a result is pending
        for (int k = 0; k < FL; k++) step(1'b1, 32'h0100_0000, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("rst_out_vo_hold", {31'b0, s_vo}, 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("rst_out_vo_drop", {31'b0, s_vo}, 32'd0);

        // Random traffic against the reference
        begin
            int target;
            int cyc;
            logic [DW-1:0] d;
            target = n_out + 100;
            cyc = 0;
            while (n_out < target && cyc < 20000) begin
                if ($urandom_range(0, 1) == 1) d = $urandom;
                else d = DW'($signed($urandom_range(0, 4096)) - 2048) <<< 16;
                step($urandom_range(0, 3) != 0, d,
                     $urandom_range(0, 2) != 0, 1'b0);
                cyc++;
            end
            chk("rand_frames", DW'(n_out), DW'(target));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
